// File: rtl/skid_pipe_reg.sv
// skid_pipe_reg: two-entry (main + skid) handshaked pipeline register.
// in_ready, out_valid, out_data and count all come straight from flops.
// flush drops every held word; rst also clears the data registers.
module skid_pipe_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        count
);

    // The state encoding equals the occupancy, so count can be loaded directly.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q,  main_d;
    logic [DATA_W-1:0] skid_q,  skid_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [1:0]        count_q;
    logic              in_xfer_s;
    logic              out_xfer_s;

    assign in_xfer_s  = in_valid  & in_ready_q;
    assign out_xfer_s = out_valid_q & out_ready;

    // Next-state and data-load selection; flush wins over every handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end else if (in_xfer_s) begin
                        skid_d  = in_data;
                        state_d = ST_TWO;
                    end else if (out_xfer_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain path can move.
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State, data and registered handshake outputs, all derived from state_d.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= {DATA_W{1'b0}};
            skid_q      <= {DATA_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d == ST_ONE) || (state_d == ST_TWO);
            count_q     <= state_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign count     = count_q;

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Self-checking bench for skid_pipe_reg using a reference queue scoreboard.
module tb_skid_pipe_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [1:0]  count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] sb_q[$];

    skid_pipe_reg #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns the oldest expected word, or X when none is expected.
    function automatic logic [31:0] pop_exp();
        if (sb_q.size() == 0) return 32'hxxxxxxxx;
        return sb_q.pop_front();
    endfunction

    // Drive one cycle: outputs are sampled #1 after the previous edge, so
    // the handshake seen here is what the DUT acts on at the next edge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic ordy,
                         input logic fl, input logic rs,
                         output logic got, output logic [31:0] gdata, output logic acc);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #1;
        got   = out_valid & ordy & ~fl & ~rs;
        gdata = out_data;
        acc   = v & in_ready & ~fl & ~rs;
        if (fl || rs) sb_q.delete();
        else if (acc) sb_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic g, a;
        logic [31:0] gd;
        cycle(1'b1, 32'h1234, 1'b1, 1'b0, 1'b1, g, gd, a);
        cycle(1'b1, 32'h5678, 1'b1, 1'b1, 1'b1, g, gd, a);
        tests_run++;
        if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 2'd0} || out_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset: got v=%b r=%b cnt=%0d d=%h, want v=0 r=1 cnt=0 d=0",
                     out_valid, in_ready, count, out_data);
        end
    endtask

    task automatic test_stream();
        logic g, a;
        logic [31:0] gd, exp;
        int delivered = 0;
        for (int i = 1; i <= 9; i++) begin
            cycle((i <= 8), 32'(i), 1'b1, 1'b0, 1'b0, g, gd, a);
            if (g) begin
                delivered++;
                exp = pop_exp();
                tests_run++;
                if (gd !== exp) begin
                    tests_failed++;
                    $display("FAIL stream_data: got %h want %h", gd, exp);
                end
            end
            if (i == 1) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== 32'd1) begin
                    tests_failed++;
                    $display("FAIL stream_latency: got v=%b d=%h want v=1 d=1", out_valid, out_data);
                end
            end
            if (i <= 8) begin
                tests_run++;
                if (count !== 2'd1 || in_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stream_occ: got cnt=%0d r=%b want cnt=1 r=1", count, in_ready);
                end
            end
        end
        tests_run++;
        if (delivered != 8 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_total: got %0d words v=%b want 8 words v=0", delivered, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic g, a, pending;
        logic [31:0] gd, exp;
        int delivered = 0;
        cycle(1'b1, 32'hAAAA0001, 1'b0, 1'b0, 1'b0, g, gd, a);
        cycle(1'b1, 32'hAAAA0002, 1'b0, 1'b0, 1'b0, g, gd, a);
        cycle(1'b1, 32'hAAAA0003, 1'b0, 1'b0, 1'b0, g, gd, a);
        tests_run++;
        if (a !== 1'b0 || count !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hAAAA0001) begin
            tests_failed++;
            $display("FAIL bp_full: got acc=%b cnt=%0d r=%b d=%h want acc=0 cnt=2 r=0 d=aaaa0001",
                     a, count, in_ready, out_data);
        end
        pending = 1'b1;
        for (int i = 0; i < 12 && delivered < 3; i++) begin
            cycle(pending, 32'hAAAA0003, 1'b1, 1'b0, 1'b0, g, gd, a);
            if (a) pending = 1'b0;
            if (g) begin
                delivered++;
                exp = pop_exp();
                tests_run++;
                if (gd !== exp || gd !== (32'hAAAA0000 + 32'(delivered))) begin
                    tests_failed++;
                    $display("FAIL bp_order: got %h want %h", gd, 32'hAAAA0000 + 32'(delivered));
                end
            end
        end
        tests_run++;
        if (delivered != 3 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_total: got %0d words v=%b want 3 words v=0", delivered, out_valid);
        end
    endtask

    task automatic test_simultaneous();
        logic g, a;
        logic [31:0] gd, exp;
        cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, g, gd, a);
        cycle(1'b1, 32'h11, 1'b1, 1'b0, 1'b0, g, gd, a);
        exp = pop_exp();
        tests_run++;
        if (g !== 1'b1 || gd !== exp || out_data !== 32'h11 || count !== 2'd1) begin
            tests_failed++;
            $display("FAIL simul: got g=%b gd=%h d=%h cnt=%0d want g=1 gd=10 d=11 cnt=1",
                     g, gd, out_data, count);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, g, gd, a);
        exp = pop_exp();
        tests_run++;
        if (g !== 1'b1 || gd !== exp || count !== 2'd0) begin
            tests_failed++;
            $display("FAIL simul_drain: got g=%b d=%h cnt=%0d want g=1 d=%h cnt=0", g, gd, count, exp);
        end
    endtask

    task automatic test_flush();
        logic g, a;
        logic [31:0] gd, exp;
        cycle(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, g, gd, a);
        cycle(1'b1, 32'h21, 1'b0, 1'b0, 1'b0, g, gd, a);
        cycle(1'b1, 32'h22, 1'b1, 1'b1, 1'b0, g, gd, a);
        tests_run++;
        if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 2'd0}) begin
            tests_failed++;
            $display("FAIL flush_state: got v=%b r=%b cnt=%0d want v=0 r=1 cnt=0",
                     out_valid, in_ready, count);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, g, gd, a);
            tests_run++;
            if (g !== 1'b0 || out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_ghost: got word %h after flush, want none", gd);
            end
        end
        cycle(1'b1, 32'h23, 1'b1, 1'b0, 1'b0, g, gd, a);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, g, gd, a);
        exp = pop_exp();
        tests_run++;
        if (g !== 1'b1 || gd !== exp || gd !== 32'h23) begin
            tests_failed++;
            $display("FAIL flush_next: got g=%b d=%h want g=1 d=23", g, gd);
        end
    endtask

    task automatic test_reset_mid();
        logic g, a;
        logic [31:0] gd, exp;
        cycle(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, g, gd, a);
        cycle(1'b1, 32'h31, 1'b0, 1'b0, 1'b0, g, gd, a);
        tests_run++;
        if (count !== 2'd2) begin
            tests_failed++;
            $display("FAIL rstmid_fill: got cnt=%0d want 2", count);
        end
        cycle(1'b1, 32'h32, 1'b0, 1'b0, 1'b1, g, gd, a);
        tests_run++;
        if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 2'd0} || out_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL rstmid_state: got v=%b r=%b cnt=%0d d=%h want v=0 r=1 cnt=0 d=0",
                     out_valid, in_ready, count, out_data);
        end
        cycle(1'b1, 32'h55, 1'b1, 1'b0, 1'b0, g, gd, a);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, g, gd, a);
        exp = pop_exp();
        tests_run++;
        if (g !== 1'b1 || gd !== exp || gd !== 32'h55) begin
            tests_failed++;
            $display("FAIL rstmid_next: got g=%b d=%h want g=1 d=55", g, gd);
        end
    endtask

    task automatic test_random();
        logic g, a, v, r, f, stall;
        logic [31:0] gd, exp, prev_d;
        for (int i = 0; i < 10000; i++) begin
            v = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 55);
            f = ($urandom_range(0, 199) == 0);
            stall  = out_valid & ~r & ~f;
            prev_d = out_data;
            cycle(v, $urandom, r, f, 1'b0, g, gd, a);
            if (g) begin
                exp = pop_exp();
                tests_run++;
                if (gd !== exp) begin
                    tests_failed++;
                    $display("FAIL rand_data: cycle %0d got %h want %h", i, gd, exp);
                end
            end
            if (stall) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== prev_d) begin
                    tests_failed++;
                    $display("FAIL rand_stable: cycle %0d got v=%b d=%h want v=1 d=%h",
                             i, out_valid, out_data, prev_d);
                end
            end
            tests_run++;
            if (count !== 2'(sb_q.size()) || out_valid !== (sb_q.size() != 0)
                || in_ready !== (sb_q.size() != 2)) begin
                tests_failed++;
                $display("FAIL rand_occ: cycle %0d got cnt=%0d v=%b r=%b want depth %0d",
                         i, count, out_valid, in_ready, sb_q.size());
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/skid_pipe_reg.md
Name: skid_pipe_reg

Overview:
- Handshaked pipeline register that replaces bare enable registers at stage boundaries once the downstream stage can stall.
- The upstream writer pushes words with a valid/ready handshake; the downstream reader pulls them with its own valid/ready handshake.
- A 2-entry skid buffer (main + skid) keeps full throughput with fully registered in_ready, out_valid and out_data.
- A flush input discards in-flight words on branch redirect or exception.

Parameters:
- DATA_W, 32, width of the data word carried through the stage.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all held words.
- in_valid  input  1  upstream word present on in_data.
- in_data  input  DATA_W  upstream word.
- in_ready  output  1  stage can accept a word this cycle (registered).
- out_valid  output  1  out_data holds a valid word (registered).
- out_data  output  DATA_W  word presented to the reader (registered, from the main entry).
- out_ready  input  1  reader consumes out_data this cycle.
- count  output  2  occupancy 0..2, for debug and verification.

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high. All state updates occur only on the rising edge of clk.
- Handshakes:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Both transfers may occur in the same cycle.
- States:
  - EMPTY: count=0.
  - ONE: main valid, count=1.
  - TWO: main and skid valid, count=2.
- Outputs per state:
  - out_valid=1 in ONE and TWO.
  - in_ready=0 only in TWO.
- Transitions when flush=0:
  - EMPTY, in_valid: main<=in_data, go to ONE.
  - EMPTY, no in_valid: stay.
  - ONE, input and output transfer: main<=in_data, stay in ONE.
  - ONE, input transfer only: skid<=in_data, go to TWO.
  - ONE, output transfer only: go to EMPTY.
  - ONE, neither: hold.
  - TWO, out_ready: main<=skid, go to ONE. No input is accepted because in_ready=0.
  - TWO, no out_ready: hold.
- Latency and throughput:
  - A word accepted at edge N is visible on out_data with out_valid=1 after edge N.
  - Sustained throughput is 1 word/cycle when out_ready stays high.
- Ordering: strict FIFO. The skid word always follows the main word. No word is duplicated or lost except by flush or rst.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- flush=1 at an edge:
  - Next state is EMPTY: out_valid=0, in_ready=1, count=0.
  - Any input or output transfer in the same cycle is void. The input word is dropped even though in_ready=1, and the output word is dropped.
  - flush overrides all other transitions.
- rst=1 at an edge:
  - Next state is EMPTY: out_valid=0, in_ready=1, count=0, out_data=0, skid=0.
  - rst has priority over flush and over any handshake.
  - Mid-transfer words are lost.
- Reset values: in_ready=1, out_valid=0, out_data=0, count=0.
- Data regs load only on the transitions listed above; they are never written while holding.
- Data is not transformed; width is DATA_W end to end.
- Illegal state encoding: recover to EMPTY on the next edge.

Test Plan:
- Reset then stream: rst for 2 cycles, then in_valid=1 with data 0x00000001..0x00000008 on consecutive cycles and out_ready=1 throughout -> out_valid rises 1 cycle after the first beat; outputs are 1..8 in order, one per cycle; count stays 1; in_ready is never 0.
- Backpressure: load 0xAAAA0001, then out_ready=0 while offering 0xAAAA0002 and 0xAAAA0003 -> count=2, in_ready=0, out_data holds 0xAAAA0001. Raise out_ready -> outputs are 0xAAAA0001 then 0xAAAA0002; 0xAAAA0003 is accepted only after in_ready returns to 1; no beat is lost.
- Simultaneous transfers in ONE: main=0x10, in_valid=1 (0x11), out_ready=1 -> next cycle out_data=0x11, count=1.
- Flush in TWO: main=0x20, skid=0x21, flush=1 while in_valid=1 (0x22) and out_ready=1 -> next cycle out_valid=0, count=0, in_ready=1; 0x20, 0x21 and 0x22 never appear afterwards.
- Reset mid-operation: count=2, assert rst together with flush=0 and in_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=1, count=0. The next accepted word 0x55 emerges first.
- Random valid/ready for 10k cycles, scoreboarded against a reference queue -> in-order, lossless delivery; out_data stable while stalled; count always equals the scoreboard depth.
